// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Time-multiplexed scan controller for a multi-digit 7-segment
//               display. It drives one shared 8-bit segment bus, one-hot digit
//               enables and inter-digit blanking, and accepts new values only at
//               frame boundaries through a req/ack handshake.
//               Optional leading-zero blanking: define DISPLAY_SCAN_LZB_EN.
// Ports       : C           - clock, rising edge
//               CLR         - asynchronous active-high reset
//               CE          - clock enable (low freezes all state and outputs)
//               value_in    - 4*DIGITS hex value, nibble k is digit k
//               dp_in       - decimal-point request per digit
//               load_req    - capture request, held until load_ack
//               load_ack    - one-cycle pulse, shadow register updated
//               segments    - Dgfedcba, active-high
//               digit_en    - one-hot digit select, zero while blanking
//               frame_start - one-cycle pulse when digit 0 enters SHOW
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 256,
  parameter int BLANK_CYC = 2
) (
  input  logic                C,
  input  logic                CLR,
  input  logic                CE,
  input  logic [4*DIGITS-1:0] value_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                load_req,
  output logic                load_ack,
  output logic [7:0]          segments,
  output logic [DIGITS-1:0]   digit_en,
  output logic                frame_start
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [IDX_W-1:0] C_LAST_IDX   = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] C_SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  typedef enum logic [0:0] {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } phase_t;

  phase_t              r_phase;
  phase_t              w_phase_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [4*DIGITS-1:0] r_val;
  logic [4*DIGITS-1:0] w_val_nxt;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   w_dp_nxt;
  logic                w_boundary;
  logic                w_ack_nxt;
  logic                w_fs_nxt;
  logic [7:0]          w_seg_nxt;
  logic [DIGITS-1:0]   w_en_nxt;
  logic [3:0]          w_nib;
  logic                w_dp_bit;
  logic                w_blank_digit;
  logic [DIGITS-1:0]   w_upper_zero;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_decode = 7'h3F;
      4'h1:    seg_decode = 7'h06;
      4'h2:    seg_decode = 7'h5B;
      4'h3:    seg_decode = 7'h4F;
      4'h4:    seg_decode = 7'h66;
      4'h5:    seg_decode = 7'h6D;
      4'h6:    seg_decode = 7'h7D;
      4'h7:    seg_decode = 7'h07;
      4'h8:    seg_decode = 7'h7F;
      4'h9:    seg_decode = 7'h6F;
      4'hA:    seg_decode = 7'h77;
      4'hB:    seg_decode = 7'h7C;
      4'hC:    seg_decode = 7'h39;
      4'hD:    seg_decode = 7'h5E;
      4'hE:    seg_decode = 7'h79;
      default: seg_decode = 7'h71;
    endcase
  endfunction

  // Phase sequencing and frame-boundary load. The shadow only changes on the
  // edge leaving the last digit's BLANK phase, so a frame never mixes values.
  always_comb begin
    w_phase_nxt = r_phase;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_val_nxt   = r_val;
    w_dp_nxt    = r_dp;
    w_boundary  = 1'b0;
    if (r_phase == ST_SHOW) begin
      if (r_cnt == C_SHOW_LAST) begin
        w_phase_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
      end
    end else if (r_cnt == C_BLANK_LAST) begin
      w_phase_nxt = ST_SHOW;
      w_cnt_nxt   = '0;
      if (r_idx == C_LAST_IDX) begin
        w_idx_nxt  = '0;
        w_boundary = 1'b1;
        if (load_req) begin
          w_val_nxt = value_in;
          w_dp_nxt  = dp_in;
        end
      end else begin
        w_idx_nxt = r_idx + 1'b1;
      end
    end
    w_ack_nxt = w_boundary & load_req;
    w_fs_nxt  = w_boundary;
  end

`ifdef DISPLAY_SCAN_LZB_EN
  // A digit is blanked when it and every more significant nibble are zero.
  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_lzb
      if (k == 0) begin : g_first
        assign w_upper_zero[k] = 1'b0;
      end else begin : g_upper
        assign w_upper_zero[k] = ~|w_val_nxt[4*DIGITS-1:4*k];
      end
    end
  endgenerate
`else
  assign w_upper_zero = '0;
`endif

  // Outputs are computed from next state so they can be registered directly.
  always_comb begin
    w_nib         = 4'h0;
    w_dp_bit      = 1'b0;
    w_blank_digit = 1'b0;
    w_en_nxt      = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_idx_nxt == IDX_W'(k)) begin
        w_nib         = w_val_nxt[4*k +: 4];
        w_dp_bit      = w_dp_nxt[k];
        w_blank_digit = w_upper_zero[k];
        w_en_nxt[k]   = 1'b1;
      end
    end
    w_seg_nxt = {w_dp_bit, (w_blank_digit ? 7'h00 : seg_decode(w_nib))};
    if (w_phase_nxt == ST_BLANK) begin
      w_seg_nxt = '0;
      w_en_nxt  = '0;
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_phase     <= ST_BLANK;
      r_idx       <= C_LAST_IDX;
      r_cnt       <= '0;
      r_val       <= '0;
      r_dp        <= '0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
      segments    <= '0;
      digit_en    <= '0;
    end else if (CE) begin
      r_phase     <= w_phase_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_val       <= w_val_nxt;
      r_dp        <= w_dp_nxt;
      load_ack    <= w_ack_nxt;
      frame_start <= w_fs_nxt;
      segments    <= w_seg_nxt;
      digit_en    <= w_en_nxt;
    end
  end

endmodule
`default_nettype wire
